noc_rr_arbiter: RTL

Parametrised output-port arbiter for the NoC router. It grants one of N_PORTS input requests to a single output channel and drives the crossbar select for that channel. Each granted flit uses an RTS/DCTS handshake with the downstream router. Compared with the fixed 5-port arbiter, it adds a configurable port count and a hold limit (MAX_HOLD) that stops one port from keeping the channel indefinitely.

---
 rtl/noc_rr_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/noc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// noc_rr_arbiter
//
// Output-port arbiter for one NoC router output channel. Picks one of
// N_PORTS requesting input ports, drives the crossbar select for the
// channel and runs the RTS/DCTS handshake with the downstream router.
// The current owner keeps priority (sticky) until it has won MAX_HOLD
// consecutive handshakes while another port is waiting; then the search
// starts at the next port in ring order. MAX_HOLD = 0 disables the limit.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous, active-high reset
//   req       in   [N_PORTS] request from input port i
//   dcts      in   downstream clear-to-send
//   grant     out  [N_PORTS] one-hot, flit from port i transferred this cycle
//   xbar_sel  out  [N_PORTS] one-hot crossbar select, zero when idle
//   rts       out  registered request-to-send toward downstream
// ---------------------------------------------------------------------------
module noc_rr_arbiter #(
    parameter int N_PORTS  = 5,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic               dcts,
    output logic [N_PORTS-1:0] grant,
    output logic [N_PORTS-1:0] xbar_sel,
    output logic               rts
);

    localparam int IDX_W  = $clog2(N_PORTS);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    // State
    logic              owner_vld_q, owner_vld_d;
    logic [IDX_W-1:0]  owner_idx_q, owner_idx_d;
    logic              rts_q, rts_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // Arbitration
    logic [N_PORTS-1:0] owner_oh;
    logic               limit_hit;
    logic [IDX_W-1:0]   start_idx;
    logic               arb_vld;
    logic [IDX_W-1:0]   arb_idx;

    // Handshake qualifiers
    logic stall;
    logic handshake;
    logic owner_change;

    // Ring addition; v never exceeds 2*N_PORTS-2 so one subtraction suffices.
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return (v >= N_PORTS) ? IDX_W'(v - N_PORTS) : IDX_W'(v);
    endfunction

    // -----------------------------------------------------------------------
    // Arbitration: first asserted request in ring order from start_idx.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        owner_oh   = '0;
        owner_oh[owner_idx_q] = 1'b1;
        limit_hit  = (MAX_HOLD != 0) && owner_vld_q && (hold_cnt_q == HOLD_MAX)
                     && (|(req & ~owner_oh));
        start_idx  = '0;
        arb_vld    = 1'b0;
        arb_idx    = '0;

        if (owner_vld_q) begin
            // At the limit the owner is searched last, so it only keeps the
            // channel when nobody else is asking.
            start_idx = limit_hit ? wrap_idx(int'(owner_idx_q) + 1) : owner_idx_q;
        end

        for (int k = 0; k < N_PORTS; k++) begin
            if (!arb_vld && req[wrap_idx(int'(start_idx) + k)]) begin
                arb_vld = 1'b1;
                arb_idx = wrap_idx(int'(start_idx) + k);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        stall     = rts_q && !dcts;
        handshake = rts_q && dcts;

        // The owner is frozen while a flit is offered but not yet accepted.
        owner_vld_d = stall ? owner_vld_q : arb_vld;
        owner_idx_d = stall ? owner_idx_q : arb_idx;

        // rts follows the current owner; it drops for one cycle after each
        // completed handshake, giving the gap in which the owner may switch.
        rts_d = owner_vld_q && !handshake;

        owner_change = !owner_vld_d || !owner_vld_q || (owner_idx_d != owner_idx_q);

        hold_cnt_d = hold_cnt_q;
        if (MAX_HOLD == 0) begin
            hold_cnt_d = '0;
        end else if (owner_change) begin
            // A new owner starts its quota from zero, even if the old owner
            // was granted in the same cycle.
            hold_cnt_d = '0;
        end else if (handshake && owner_vld_q && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            owner_vld_q <= 1'b0;
            owner_idx_q <= '0;
            rts_q       <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_idx_q <= owner_idx_d;
            rts_q       <= rts_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        xbar_sel = owner_vld_q ? owner_oh : '0;
        grant    = (handshake && owner_vld_q) ? owner_oh : '0;
        rts      = rts_q;
    end

endmodule
